pipe_adder: RTL
===============

# pipe_adder

Parametrised, pipelined successor to the 4-bit ripple carry adder. Computes `a + b + cin` or `a - b` on WIDTH-bit operands. The carry chain is split into STAGES equal chunks, with the carry registered between chunks. A valid/ready handshake on both sides lets the block sit between arithmetic datapath stages, sustaining one result per cycle with backpressure.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (≥1); chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1).
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB (sub=1: 1 means no borrow).
- ovf  output  1  signed two's-complement overflow (see Configuration).

Clock/reset: one clock `clk`; reset `rst` is synchronous and active-high.

## Operation
- Stage k (0..STAGES-1) adds chunk k (bits k*CW+CW-1 : k*CW) of a and b', plus the carry registered by stage k-1. Stage 0 uses the carry-in (cin, or 1 when sub=1).
- b' = sub ? ~b : b; the inversion happens at the input before registering.
- Operand chunks not yet consumed are carried forward through skew registers. Completed result chunks are carried forward through deskew registers, so sum emerges aligned.
- Each stage holds a valid bit; bubbles are not collapsed.
- Global advance: adv = !out_valid | out_ready. All stage registers, including valid bits, load only when adv=1. in_ready = adv.
- Input accepted when in_valid & in_ready; a beat with in_valid=0 inserts a bubble (valid bit 0).
- cout = carry out of the final chunk. ovf = carry into MSB XOR carry out of MSB, registered with the last stage.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset (rst=1 at an edge): all valid bits 0, out_valid=0, sum=0, cout=0, ovf=0. Skew/deskew registers are cleared to 0. in_ready=1 in the first cycle after reset.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. it is visible STAGES cycles after acceptance. STAGES=1 gives one registered stage.
- Throughput: one beat per cycle while out_ready=1.
- Stall: out_valid=1 & out_ready=0 → the whole pipe freezes, in_ready=0, and sum/cout/ovf hold stable. out_valid must not drop until the beat is taken.
- Simultaneous take and accept (out_ready=1, in_valid=1) shifts the pipe one stage; no beat is lost or duplicated.
- A beat presented while in_ready=0 is not consumed; upstream holds it.
- Reset mid-operation: in-flight beats are discarded and the block returns to the reset state on that edge, even if out_ready=0.
- sub and cin are sampled only with the accepted beat.

## Configuration
- PIPE_ADDER_OVF_EN defined: ovf is computed per Operation and pipelined alongside sum.
- PIPE_ADDER_OVF_EN undefined: no overflow logic; ovf tied to constant 0. The port remains so instantiations are unchanged.

## Test plan
All with WIDTH=16, STAGES=4 unless stated.
- Reset: hold rst 2 cycles → out_valid=0, sum=16'h0000, cout=0, ovf=0, in_ready=1.
- Full carry ripple: a=16'hFFFF, b=16'h0001, cin=0, sub=0, out_ready=1 → 4 cycles later sum=16'h0000, cout=1, ovf=0.
- Subtract and overflow, back-to-back beats, each result on consecutive cycles:
  - a=5, b=7, sub=1 → sum=16'hFFFE, cout=0.
  - a=16'h7FFF, b=1, sub=0 → sum=16'h8000, ovf=1 with PIPE_ADDER_OVF_EN, ovf=0 without.
  - a=16'h1234, b=16'h1111, cin=1 → sum=16'h2346, cout=0.
- Backpressure: stream 6 beats (a=i, b=i), drop out_ready for 3 cycles mid-stream → in_ready=0 while stalled, sum held, and all 6 results 2*i appear in order with no loss or duplication.
- Reset mid-flight: accept 3 beats, assert rst one cycle before the first output → no out_valid afterwards until new input, and the next accepted beat has correct latency.
- Degenerate config: WIDTH=8, STAGES=1, a=8'hC8, b=8'h64 → one cycle later sum=8'h2C, cout=1.

Source files
------------

// File: rtl/pipe_adder_if.sv
// Handshake and operand/result bundle for pipe_adder; the adder connects as slave,
// the producer/consumer side as master.
interface pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract with the carry chain cut into STAGES chunks and a
// valid/ready handshake on both sides. Define PIPE_ADDER_OVF_EN to compute ovf.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic        clk,
  input  logic        rst,
  pipe_adder_if.slave bus
);
  localparam int CW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub | bus.cin;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // IW: operand bits still pending at this stage's input; RW: result bits done after it
      localparam int IW = WIDTH - gi * CW;
      localparam int RW = (gi + 1) * CW;

      logic [IW-1:0] a_in;
      logic [IW-1:0] b_in;
      logic          c_in;
      logic          v_in;
      logic [CW:0]   chunk_d;
      logic [RW-1:0] res_d;
      logic [RW-1:0] res_q;
      logic          carry_q;
      logic          valid_q;

      if (gi == 0) begin : g_head
        assign a_in  = bus.a;
        assign b_in  = b_eff;
        assign c_in  = cin_eff;
        assign v_in  = bus.in_valid;
        assign res_d = chunk_d[CW-1:0];
      end else begin : g_body
        assign a_in  = g_stage[gi-1].g_skew.a_q;
        assign b_in  = g_stage[gi-1].g_skew.b_q;
        assign c_in  = g_stage[gi-1].carry_q;
        assign v_in  = g_stage[gi-1].valid_q;
        assign res_d = {chunk_d[CW-1:0], g_stage[gi-1].res_q};
      end

      assign chunk_d = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          carry_q <= 1'b0;
          res_q   <= '0;
        end else if (adv) begin
          valid_q <= v_in;
          carry_q <= chunk_d[CW];
          res_q   <= res_d;
        end
      end

      // Upper operand chunks ride along until their stage consumes them
      if (gi < STAGES - 1) begin : g_skew
        logic [IW-CW-1:0] a_q;
        logic [IW-CW-1:0] b_q;

        always_ff @(posedge clk) begin
          if (rst) begin
            a_q <= '0;
            b_q <= '0;
          end else if (adv) begin
            a_q <= a_in[IW-1:CW];
            b_q <= b_in[IW-1:CW];
          end
        end
      end
    end
  endgenerate

  assign adv           = ~g_stage[STAGES-1].valid_q | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = g_stage[STAGES-1].valid_q;
  assign bus.sum       = g_stage[STAGES-1].res_q;
  assign bus.cout      = g_stage[STAGES-1].carry_q;

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits
  assign ovf_d = g_stage[STAGES-1].a_in[CW-1] ^ g_stage[STAGES-1].b_in[CW-1]
               ^ g_stage[STAGES-1].chunk_d[CW-1] ^ g_stage[STAGES-1].chunk_d[CW];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule
